// File: rtl/ysyx_22040237_lsu_mem_ctrl_pkg.sv
// Shared definitions for the LSU data-memory controller: size encodings,
// FSM state encoding and the per-size byte/data mask tables.
package ysyx_22040237_lsu_mem_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REQ    = 2'd1;
   localparam logic [1:0] ST_WAIT_R = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      REQ    = ST_REQ,
      WAIT_R = ST_WAIT_R,
      RESP   = ST_RESP
   } state_e;

   // Byte strobes of an access of the given size placed at lane 0.
   function automatic logic [7:0] base_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE:  base_mask = 8'h01;
         SZ_HALF:  base_mask = 8'h03;
         SZ_WORD:  base_mask = 8'h0F;
         default:  base_mask = 8'hFF;
      endcase
   endfunction

   // Address-offset bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_bits(input logic [1:0] size);
      case (size)
         SZ_BYTE:  align_bits = 3'b000;
         SZ_HALF:  align_bits = 3'b001;
         SZ_WORD:  align_bits = 3'b011;
         default:  align_bits = 3'b111;
      endcase
   endfunction

   // Bit mask keeping only the bytes covered by an access of the given size.
   function automatic logic [63:0] data_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE:  data_mask = 64'h0000_0000_0000_00FF;
         SZ_HALF:  data_mask = 64'h0000_0000_0000_FFFF;
         SZ_WORD:  data_mask = 64'h0000_0000_FFFF_FFFF;
         default:  data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Combinational lane alignment for the LSU memory controller.
// The misalignment check has its own size/offset inputs because it judges the
// incoming request, while the data paths work on the latched request.
module ysyx_22040237_lsu_align
   import ysyx_22040237_lsu_mem_ctrl_pkg::*;
(
   input  logic [1:0]  chk_size,
   input  logic [2:0]  chk_off,
   output logic        misaligned,
   input  logic [1:0]  size,
   input  logic [2:0]  off,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [7:0]  wmask,
   output logic [63:0] wdata_sh,
   output logic [63:0] rdata_ext
);

   logic [5:0] bit_off;

   assign bit_off    = {off, 3'b000};
   assign misaligned = |(chk_off & align_bits(chk_size));
   assign wmask      = base_mask(size) << off;
   assign wdata_sh   = wdata << bit_off;
   assign rdata_ext  = (rdata >> bit_off) & data_mask(size);

endmodule

// File: rtl/ysyx_22040237_lsu_mem_ctrl.sv
// Multi-cycle data-memory access controller between the LSU and a 64-bit
// valid/ready memory bus. One request at a time; loads wait for read data.
// Optional read/handshake timeout: define YSYX_22040237_LSU_MEM_TIMEOUT_EN.
module ysyx_22040237_lsu_mem_ctrl
   import ysyx_22040237_lsu_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_ren_i,
   input  logic              req_wen_i,
   input  logic [1:0]        req_size_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   output logic              busy_o,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wmask_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   if (DATA_W != 64 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("ysyx_22040237_lsu_mem_ctrl: DATA_W must be 64 and TIMEOUT_CYC >= 2");
   end

   state_e            state, state_nx;
   logic              ren_q, wen_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic              req_misaligned;
   logic              req_illegal;
   logic [7:0]        wmask;
   logic [DATA_W-1:0] wdata_sh;
   logic [DATA_W-1:0] rdata_ext;
   logic              tmo;

   ysyx_22040237_lsu_align u_align (
      .chk_size   (req_size_i),
      .chk_off    (req_addr_i[2:0]),
      .misaligned (req_misaligned),
      .size       (size_q),
      .off        (addr_q[2:0]),
      .wdata      (wdata_q),
      .rdata      (mem_rdata_i),
      .wmask      (wmask),
      .wdata_sh   (wdata_sh),
      .rdata_ext  (rdata_ext)
   );

   assign req_illegal = req_misaligned | (req_ren_i & req_wen_i) | ~(req_ren_i | req_wen_i);

`ifdef YSYX_22040237_LSU_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   logic [CNT_W-1:0] cnt;

   // Cycles spent in REQ/WAIT_R; IDLE is the only way into REQ, so clear there.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                cnt <= '0;
      else if (state == IDLE)                  cnt <= '0;
      else if (state == REQ || state == WAIT_R) cnt <= cnt + 1'b1;
   end

   assign tmo = (state == REQ || state == WAIT_R) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign tmo = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state decode; a timeout overrides any bus event in the same cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid_i) state_nx = req_illegal ? RESP : REQ;
         REQ:     if (tmo) state_nx = RESP;
                  else if (mem_req_ready_i) state_nx = ren_q ? WAIT_R : RESP;
         WAIT_R:  if (tmo || mem_rvalid_i) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request fields, load data and error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid_i) begin
               ren_q   <= req_ren_i;
               wen_q   <= req_wen_i;
               size_q  <= req_size_i;
               addr_q  <= req_addr_i;
               wdata_q <= req_wdata_i;
               rdata_q <= '0;
               err_q   <= req_illegal;
            end
            REQ: if (tmo) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
            WAIT_R: if (tmo) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end else if (mem_rvalid_i) begin
               rdata_q <= rdata_ext;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from registered state only; bus fields are zero outside REQ.
   assign req_ready_o     = (state == IDLE);
   assign busy_o          = (state != IDLE);
   assign mem_req_valid_o = (state == REQ) && !tmo;
   assign mem_we_o        = (state == REQ) && wen_q;
   assign mem_addr_o      = (state == REQ) ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
   assign mem_wmask_o     = (state == REQ) ? wmask : 8'h00;
   assign mem_wdata_o     = (state == REQ) ? wdata_sh : '0;
   assign resp_valid_o    = (state == RESP);
   assign resp_rdata_o    = (state == RESP) ? rdata_q : '0;
   assign resp_err_o      = (state == RESP) && err_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu_mem_ctrl.sv
// Directed bench for ysyx_22040237_lsu_mem_ctrl (TIMEOUT_CYC=8).
module tb_ysyx_22040237_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_ren_i = 1'b0;
   logic        req_wen_i = 1'b0;
   logic [1:0]  req_size_i = 2'd0;
   logic [63:0] req_addr_i = '0;
   logic [63:0] req_wdata_i = '0;
   logic        resp_valid_o;
   logic [63:0] resp_rdata_o;
   logic        resp_err_o;
   logic        busy_o;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i = 1'b0;
   logic        mem_we_o;
   logic [63:0] mem_addr_o;
   logic [7:0]  mem_wmask_o;
   logic [63:0] mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic [63:0] mem_rdata_i = '0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ysyx_22040237_lsu_mem_ctrl #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_ren_i       (req_ren_i),
      .req_wen_i       (req_wen_i),
      .req_size_i      (req_size_i),
      .req_addr_i      (req_addr_i),
      .req_wdata_i     (req_wdata_i),
      .resp_valid_o    (resp_valid_o),
      .resp_rdata_o    (resp_rdata_o),
      .resp_err_o      (resp_err_o),
      .busy_o          (busy_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_we_o        (mem_we_o),
      .mem_addr_o      (mem_addr_o),
      .mem_wmask_o     (mem_wmask_o),
      .mem_wdata_o     (mem_wdata_o),
      .mem_rvalid_i    (mem_rvalid_i),
      .mem_rdata_i     (mem_rdata_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ren, input logic wen, input logic [1:0] size,
                        input logic [63:0] addr, input logic [63:0] wdata);
      req_valid_i = 1'b1;
      req_ren_i   = ren;
      req_wen_i   = wen;
      req_size_i  = size;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      step();
      req_valid_i = 1'b0;
      req_ren_i   = 1'b0;
      req_wen_i   = 1'b0;
   endtask

   initial begin
      // Reset values
      #2;
      chk("rst_ready",   {63'd0, req_ready_o}, 64'd1);
      chk("rst_busy",    {63'd0, busy_o}, 64'd0);
      chk("rst_resp_v",  {63'd0, resp_valid_o}, 64'd0);
      chk("rst_memv",    {63'd0, mem_req_valid_o}, 64'd0);
      chk("rst_mask",    {56'd0, mem_wmask_o}, 64'd0);
      chk("rst_addr",    mem_addr_o, 64'd0);
      #10 rst = 1'b1;
      step();

      // 1: sd aligned, ready held high
      mem_req_ready_i = 1'b1;
      issue(1'b0, 1'b1, 2'd3, 64'h8000_0008, 64'h1122_3344_5566_7788);
      chk("sd_memv",  {63'd0, mem_req_valid_o}, 64'd1);
      chk("sd_we",    {63'd0, mem_we_o}, 64'd1);
      chk("sd_mask",  {56'd0, mem_wmask_o}, 64'hFF);
      chk("sd_addr",  mem_addr_o, 64'h8000_0008);
      chk("sd_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
      chk("sd_busy",  {63'd0, busy_o}, 64'd1);
      chk("sd_rdy",   {63'd0, req_ready_o}, 64'd0);
      chk("sd_nresp", {63'd0, resp_valid_o}, 64'd0);
      step();
      chk("sd_resp",  {63'd0, resp_valid_o}, 64'd1);
      chk("sd_err",   {63'd0, resp_err_o}, 64'd0);
      chk("sd_rdata", resp_rdata_o, 64'd0);
      step();
      chk("sd_idle",  {63'd0, busy_o}, 64'd0);
      chk("sd_done",  {63'd0, resp_valid_o}, 64'd0);

      // 2: sb at byte 3
      issue(1'b0, 1'b1, 2'd0, 64'h8000_0003, 64'h0000_0000_0000_00AB);
      chk("sb_mask",  {56'd0, mem_wmask_o}, 64'h08);
      chk("sb_wdata", mem_wdata_o, 64'h0000_0000_AB00_0000);
      chk("sb_addr",  mem_addr_o, 64'h8000_0000);
      step();
      chk("sb_resp",  {63'd0, resp_valid_o}, 64'd1);
      chk("sb_err",   {63'd0, resp_err_o}, 64'd0);
      step();

      // 3: lw at offset 4, read data 5 cycles after the handshake
      issue(1'b1, 1'b0, 2'd2, 64'h8000_0004, 64'd0);
      chk("lw_memv",  {63'd0, mem_req_valid_o}, 64'd1);
      chk("lw_we",    {63'd0, mem_we_o}, 64'd0);
      chk("lw_mask",  {56'd0, mem_wmask_o}, 64'hF0);
      chk("lw_addr",  mem_addr_o, 64'h8000_0000);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("lw_wait_busy", {63'd0, busy_o}, 64'd1);
         chk("lw_wait_nresp", {63'd0, resp_valid_o}, 64'd0);
         chk("lw_wait_memv", {63'd0, mem_req_valid_o}, 64'd0);
         step();
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'hDEAD_BEEF_0123_4567;
      step();
      mem_rvalid_i = 1'b0;
      chk("lw_resp",  {63'd0, resp_valid_o}, 64'd1);
      chk("lw_rdata", resp_rdata_o, 64'h0000_0000_DEAD_BEEF);
      chk("lw_err",   {63'd0, resp_err_o}, 64'd0);
      chk("lw_busy",  {63'd0, busy_o}, 64'd1);
      step();

      // lb at byte 5: request held while ready low, stray rvalid in REQ ignored
      mem_req_ready_i = 1'b0;
      issue(1'b1, 1'b0, 2'd0, 64'h8000_0005, 64'd0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      chk("lb_hold_v",    {63'd0, mem_req_valid_o}, 64'd1);
      chk("lb_hold_mask", {56'd0, mem_wmask_o}, 64'h20);
      chk("lb_hold_nr",   {63'd0, resp_valid_o}, 64'd0);
      mem_rvalid_i    = 1'b0;
      mem_req_ready_i = 1'b1;
      step();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h1122_3344_5566_7788;
      step();
      mem_rvalid_i = 1'b0;
      chk("lb_resp",  {63'd0, resp_valid_o}, 64'd1);
      chk("lb_rdata", resp_rdata_o, 64'h0000_0000_0000_0033);
      step();

      // 4: misaligned lh -> error, no bus request
      issue(1'b1, 1'b0, 2'd1, 64'h8000_0001, 64'd0);
      chk("lh_memv",  {63'd0, mem_req_valid_o}, 64'd0);
      chk("lh_resp",  {63'd0, resp_valid_o}, 64'd1);
      chk("lh_err",   {63'd0, resp_err_o}, 64'd1);
      step();
      chk("lh_idle",  {63'd0, req_ready_o}, 64'd1);

      // ren and wen together -> error
      issue(1'b1, 1'b1, 2'd3, 64'h8000_0010, 64'd0);
      chk("rw_memv",  {63'd0, mem_req_valid_o}, 64'd0);
      chk("rw_err",   {63'd0, resp_err_o}, 64'd1);
      step();

      // 5: reset during an unacknowledged load
      mem_req_ready_i = 1'b0;
      issue(1'b1, 1'b0, 2'd3, 64'h8000_0010, 64'd0);
      chk("rm_memv1", {63'd0, mem_req_valid_o}, 64'd1);
      step();
      rst = 1'b0;
      #1;
      chk("rm_memv0", {63'd0, mem_req_valid_o}, 64'd0);
      chk("rm_busy",  {63'd0, busy_o}, 64'd0);
      chk("rm_ready", {63'd0, req_ready_o}, 64'd1);
      chk("rm_mask",  {56'd0, mem_wmask_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      mem_req_ready_i = 1'b1;
      issue(1'b0, 1'b1, 2'd2, 64'h8000_0010, 64'h0000_0000_CAFE_BABE);
      chk("pr_mask",  {56'd0, mem_wmask_o}, 64'h0F);
      chk("pr_wdata", mem_wdata_o, 64'h0000_0000_CAFE_BABE);
      step();
      chk("pr_resp",  {63'd0, resp_valid_o}, 64'd1);
      chk("pr_err",   {63'd0, resp_err_o}, 64'd0);
      step();

      // 6: load whose read data never arrives
      issue(1'b1, 1'b0, 2'd3, 64'h8000_0018, 64'd0);
`ifdef YSYX_22040237_LSU_MEM_TIMEOUT_EN
      for (int i = 0; i < 7; i++) begin
         chk("to_wait", {63'd0, resp_valid_o}, 64'd0);
         step();
      end
      step();
      chk("to_resp",  {63'd0, resp_valid_o}, 64'd1);
      chk("to_err",   {63'd0, resp_err_o}, 64'd1);
      chk("to_rdata", resp_rdata_o, 64'd0);
      step();
      chk("to_idle",  {63'd0, busy_o}, 64'd0);
`else
      for (int i = 0; i < 20; i++) step();
      chk("nt_busy",  {63'd0, busy_o}, 64'd1);
      chk("nt_nresp", {63'd0, resp_valid_o}, 64'd0);
      chk("nt_memv",  {63'd0, mem_req_valid_o}, 64'd0);
      rst = 1'b0;
      #1;
      chk("nt_rst",   {63'd0, busy_o}, 64'd0);
      rst = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_22040237_lsu_mem_ctrl.md
Name: ysyx_22040237_lsu_mem_ctrl

Overview:
Multi-cycle data-memory access controller placed directly downstream of the LSU, between the LSU and the data-memory bus.
- Accepts one load or store request at a time from the LSU.
- Aligns the request onto a 64-bit, 8-byte-aligned valid/ready memory bus.
- Waits for the read data when the request is a load.
- Returns the raw data shifted down to byte 0; the LSU still performs the sign/zero extension.
- Drives busy_o so the pipeline stalls while an access is outstanding.

Parameters:
ADDR_W, 64, request/bus address width
DATA_W, 64, bus data width; only 64 is supported
TIMEOUT_CYC, 256, cycle limit for a read response (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req_valid_i  input  1  LSU request valid
req_ready_o  output  1  controller can accept a request
req_ren_i  input  1  load request
req_wen_i  input  1  store request
req_size_i  input  2  0=byte, 1=half, 2=word, 3=dword
req_addr_i  input  ADDR_W  byte address (the LSU's alu result)
req_wdata_i  input  DATA_W  store data, LSB-aligned
resp_valid_o  output  1  one-cycle completion pulse
resp_rdata_o  output  DATA_W  load data shifted down to bit 0; zero for stores
resp_err_o  output  1  misaligned access, ren+wen conflict, or timeout; qualified by resp_valid_o
busy_o  output  1  request outstanding (pipeline stall)
mem_req_valid_o  output  1  bus request valid
mem_req_ready_i  input  1  bus accepts the request
mem_we_o  output  1  1 = write, 0 = read
mem_addr_o  output  ADDR_W  request address with [2:0] forced to 0
mem_wmask_o  output  8  byte-lane strobes
mem_wdata_o  output  DATA_W  lane-shifted write data
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  DATA_W  read data for the whole 8-byte word

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE. All outputs are 0, except req_ready_o=1. All latched fields are 0.
- Interface: combinational outputs are decoded from registered state and latched fields only. There is no combinational path from req_*_i to mem_*_o.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_ready_o=1 and busy_o=0.
  - On req_valid_i, latch ren, wen, size, addr and wdata.
  - Illegal request (misaligned, ren&&wen, or neither set) -> RESP with err=1; no bus transaction is issued.
  - Legal request -> REQ.
- Misaligned rule: (addr[2:0] & (bytes-1)) != 0, where bytes = 1 << size.
- REQ:
  - mem_req_valid_o=1, held stable until mem_req_ready_i.
  - Base mask by size: 0x01, 0x03, 0x0F, 0xFF. mem_wmask_o = base << addr[2:0] for both reads and writes.
  - mem_wdata_o = wdata << (8*addr[2:0]), truncated to 64 bits.
  - On handshake: a store -> RESP (posted write); a load -> WAIT_R.
- WAIT_R:
  - mem_rvalid_i is honoured only in this state and ignored elsewhere. Earliest read data is therefore one cycle after the request handshake.
  - On mem_rvalid_i, capture mem_rdata_i >> (8*addr[2:0]), masked to the access size (upper bytes zero) -> RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle, with resp_rdata_o and resp_err_o from registers -> IDLE.
  - There is no response back-pressure; the LSU always consumes.
- busy_o = (state != IDLE).
- Latency: store = 3 cycles from acceptance to resp_valid_o with zero bus wait. Load = 4 cycles minimum (rvalid arriving one cycle after the handshake). Illegal request = 2 cycles.
- Back-to-back: a new request is accepted the cycle after RESP, when the FSM is back in IDLE.
- Reset mid-operation: immediate return to IDLE and mem_req_valid_o drops, even during an unacknowledged request. The bus slave must tolerate the abandoned request. No response is generated.

Optional Feature:
Macro: YSYX_22040237_LSU_MEM_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and counts in REQ and WAIT_R. Reaching TIMEOUT_CYC-1 forces RESP with err=1 and rdata=0, and sets mem_req_valid_o=0.
- Undefined: no counter; the FSM waits indefinitely and err is raised only for illegal requests.

Decomposition:
- Shared package/header: size encodings, the state encoding localparams, and the base-mask table.
- Natural sub-module ysyx_22040237_lsu_align: a purely combinational block computing the misaligned flag, wmask, shifted wdata and extracted rdata from size, addr[2:0] and the data inputs.

Test Plan:
1. sd, addr 0x80000008, wdata 0x1122334455667788, ready held high -> mem_wmask_o=0xFF, mem_addr_o=0x80000008, resp_valid_o 3 cycles after acceptance, err=0.
2. sb, addr 0x80000003, wdata 0xAB -> mem_wmask_o=0x08, mem_wdata_o[31:24]=0xAB, mem_addr_o=0x80000000.
3. lw, addr 0x80000004, mem_rdata_i=0xDEADBEEF_01234567, rvalid delayed 5 cycles -> resp_rdata_o=0x00000000DEADBEEF, busy_o high throughout.
4. lh, addr 0x80000001 -> no mem_req_valid_o, resp_valid_o 2 cycles later with err=1.
5. Load with mem_req_ready_i held low for 4 cycles, rst asserted in the 3rd cycle -> outputs return to reset values immediately. Next request after reset completes normally.
6. With the timeout macro and TIMEOUT_CYC=8, load with rvalid never asserted -> resp_valid_o with err=1 eight cycles after entering REQ. Without the macro the FSM is still in WAIT_R.
